// File: rtl/icache_refill_ctrl.sv
// ICache line refill sequencer: IF2 miss -> one memory line read -> per-beat data writes -> tag write.
// Optional feature macro ICACHE_REFILL_CRITICAL_FIRST_EN: critical-beat-first request with early stall release.
module icache_refill_ctrl #(
  parameter int ASSOC       = 2,
  parameter int LINE_BEATS  = 4,
  parameter int BEAT_WIDTH  = 64,
  parameter int PADDR_WIDTH = 34,
  localparam int WAY_W      = (ASSOC > 1) ? $clog2(ASSOC) : 1,
  localparam int BEAT_W     = $clog2(LINE_BEATS)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_flush,
  input  logic                   i_miss,
  input  logic [PADDR_WIDTH-1:0] i_miss_paddr,
  output logic                   o_stall,
  output logic                   o_mem_req_valid,
  input  logic                   i_mem_req_ready,
  output logic [PADDR_WIDTH-1:0] o_mem_req_addr,
  input  logic                   i_mem_resp_valid,
  input  logic [BEAT_WIDTH-1:0]  i_mem_resp_data,
  output logic                   o_wr_data_en,
  output logic                   o_wr_tag_en,
  output logic [WAY_W-1:0]       o_wr_way,
  output logic [PADDR_WIDTH-1:0] o_wr_paddr,
  output logic [BEAT_W-1:0]      o_wr_beat,
  output logic [BEAT_WIDTH-1:0]  o_wr_data
);

  localparam int BYTE_W = $clog2(BEAT_WIDTH / 8);
  localparam int OFF_W  = BYTE_W + BEAT_W;

`ifdef ICACHE_REFILL_CRITICAL_FIRST_EN
  localparam bit CRIT_FIRST = 1'b1;
`else
  localparam bit CRIT_FIRST = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_FILL   = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  state_t                 state_reg, state_next;
  logic [PADDR_WIDTH-1:0] line_addr_reg, line_addr_next;
  logic [PADDR_WIDTH-1:0] req_addr_reg, req_addr_next;
  logic [WAY_W-1:0]       victim_reg, victim_next;
  logic [BEAT_W-1:0]      crit_reg, crit_next;
  logic [BEAT_W-1:0]      cnt_reg, cnt_next;
  logic [BEAT_W-1:0]      num_reg, num_next;
  logic                   drop_reg, drop_next;
  logic                   last_reg, last_next;
  logic                   released_reg, released_next;
  logic                   wr_data_en_reg, wr_data_en_next;
  logic                   wr_crit_reg, wr_crit_next;
  logic [BEAT_W-1:0]      wr_beat_reg, wr_beat_next;
  logic [BEAT_WIDTH-1:0]  wr_data_reg, wr_data_next;

  logic [PADDR_WIDTH-1:0] line_addr_in;
  logic [PADDR_WIDTH-1:0] req_addr_in;
  logic [BEAT_W-1:0]      crit_beat_in;
  logic                   miss_take;
  logic                   dropping;
  logic                   beat_final;
  logic                   unused_byte_bits;

  // Byte-within-beat bits are always cleared; beat offset bits survive only in the request of a critical-first build.
  for (genvar gi = 0; gi < PADDR_WIDTH; gi++) begin : g_addr
    if (gi >= OFF_W) begin : g_line
      assign line_addr_in[gi] = i_miss_paddr[gi];
      assign req_addr_in[gi]  = i_miss_paddr[gi];
    end else if (CRIT_FIRST && (gi >= BYTE_W)) begin : g_crit
      assign line_addr_in[gi] = 1'b0;
      assign req_addr_in[gi]  = i_miss_paddr[gi];
    end else begin : g_off
      assign line_addr_in[gi] = 1'b0;
      assign req_addr_in[gi]  = 1'b0;
    end
  end

  assign crit_beat_in     = CRIT_FIRST ? i_miss_paddr[BYTE_W +: BEAT_W] : '0;
  assign unused_byte_bits = ^i_miss_paddr[BYTE_W-1:0];

  assign miss_take  = i_miss & ~i_flush;
  assign dropping   = drop_reg | i_flush;
  assign beat_final = (num_reg == BEAT_W'(LINE_BEATS - 1));

  always_comb begin
    state_next      = state_reg;
    line_addr_next  = line_addr_reg;
    req_addr_next   = req_addr_reg;
    victim_next     = victim_reg;
    crit_next       = crit_reg;
    cnt_next        = cnt_reg;
    num_next        = num_reg;
    drop_next       = drop_reg;
    last_next       = 1'b0;
    released_next   = released_reg;
    wr_data_en_next = 1'b0;
    wr_crit_next    = 1'b0;
    wr_beat_next    = wr_beat_reg;
    wr_data_next    = wr_data_reg;

    unique case (state_reg)
      ST_IDLE: begin
        if (miss_take) begin
          line_addr_next = line_addr_in;
          req_addr_next  = req_addr_in;
          crit_next      = crit_beat_in;
          drop_next      = 1'b0;
          released_next  = 1'b0;
          state_next     = ST_REQ;
        end
      end
      ST_REQ: begin
        // Once the handshake happens the response is committed, so a coincident flush only marks it as dropped.
        if (i_mem_req_ready) begin
          state_next = ST_FILL;
          cnt_next   = crit_reg;
          num_next   = '0;
          drop_next  = i_flush;
        end else if (i_flush) begin
          state_next = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (i_flush) begin
          drop_next = 1'b1;
        end
        if (CRIT_FIRST && wr_data_en_reg && wr_crit_reg) begin
          released_next = 1'b1;
        end
        if (last_reg) begin
          // Final data write is on the array port this cycle; tag follows next cycle.
          if (dropping) begin
            state_next = ST_IDLE;
            drop_next  = 1'b0;
          end else begin
            state_next = ST_COMMIT;
          end
        end else if (i_mem_resp_valid) begin
          wr_data_en_next = ~dropping;
          wr_crit_next    = (num_reg == '0);
          wr_beat_next    = cnt_reg;
          wr_data_next    = i_mem_resp_data;
          cnt_next        = cnt_reg + 1'b1;
          num_next        = num_reg + 1'b1;
          if (beat_final) begin
            if (dropping) begin
              state_next = ST_IDLE;
              drop_next  = 1'b0;
            end else begin
              last_next = 1'b1;
            end
          end
        end
      end
      ST_COMMIT: begin
        state_next  = ST_IDLE;
        victim_next = (victim_reg == WAY_W'(ASSOC - 1)) ? '0 : victim_reg + 1'b1;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg      <= ST_IDLE;
      line_addr_reg  <= '0;
      req_addr_reg   <= '0;
      victim_reg     <= '0;
      crit_reg       <= '0;
      cnt_reg        <= '0;
      num_reg        <= '0;
      drop_reg       <= 1'b0;
      last_reg       <= 1'b0;
      released_reg   <= 1'b0;
      wr_data_en_reg <= 1'b0;
      wr_crit_reg    <= 1'b0;
      wr_beat_reg    <= '0;
      wr_data_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      line_addr_reg  <= line_addr_next;
      req_addr_reg   <= req_addr_next;
      victim_reg     <= victim_next;
      crit_reg       <= crit_next;
      cnt_reg        <= cnt_next;
      num_reg        <= num_next;
      drop_reg       <= drop_next;
      last_reg       <= last_next;
      released_reg   <= released_next;
      wr_data_en_reg <= wr_data_en_next;
      wr_crit_reg    <= wr_crit_next;
      wr_beat_reg    <= wr_beat_next;
      wr_data_reg    <= wr_data_next;
    end
  end

  assign o_stall = ((state_reg != ST_IDLE) & ~drop_reg & ~(CRIT_FIRST & released_reg))
                 | ((state_reg == ST_IDLE) & miss_take);
  assign o_mem_req_valid = (state_reg == ST_REQ);
  assign o_mem_req_addr  = (state_reg == ST_REQ) ? req_addr_reg : '0;
  assign o_wr_data_en    = wr_data_en_reg;
  assign o_wr_tag_en     = (state_reg == ST_COMMIT);
  assign o_wr_way        = victim_reg;
  assign o_wr_paddr      = line_addr_reg;
  assign o_wr_beat       = wr_beat_reg;
  assign o_wr_data       = wr_data_reg;

endmodule
